// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter in front of a single-cycle DMEM and a
// handshaked IO port with a bounded wait.
module mem_bus_arbiter #(
  parameter int unsigned IO_TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_m0_req,
  input  logic        i_m0_we,
  input  logic [31:0] i_m0_addr,
  input  logic [31:0] i_m0_wdata,
  output logic        o_m0_gnt,
  output logic        o_m0_rvalid,
  output logic [31:0] o_m0_rdata,
  output logic        o_m0_err,
  input  logic        i_m1_req,
  input  logic        i_m1_we,
  input  logic [31:0] i_m1_addr,
  input  logic [31:0] i_m1_wdata,
  output logic        o_m1_gnt,
  output logic        o_m1_rvalid,
  output logic [31:0] o_m1_rdata,
  output logic        o_m1_err,
  output logic        o_dmem_en,
  output logic        o_dmem_wren,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_io_req,
  output logic        o_io_wren,
  output logic [31:0] o_io_addr,
  output logic [31:0] o_io_wdata,
  input  logic        i_io_ready,
  input  logic [31:0] i_io_rdata
);

  localparam int unsigned CNT_W    = (IO_TIMEOUT > 2) ? $clog2(IO_TIMEOUT) : 1;
  localparam logic [3:0]  REG_DMEM = 4'h0;
  localparam logic [3:0]  REG_IO   = 4'h1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DMEM    = 2'd1,
    S_IO_WAIT = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_prio_m1;
  logic               r_mid;
  logic               r_we;
  logic [31:0]        r_addr;
  logic [31:0]        r_wdata;
  logic               r_err;
  logic [31:0]        r_io_rdata;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_gnt0;
  logic               w_gnt1;
  logic               w_any_gnt;
  logic               w_sel_we;
  logic [31:0]        w_sel_addr;
  logic [31:0]        w_sel_wdata;
  logic [3:0]         w_region;
  logic               w_timeout;
  logic [31:0]        w_rdata;

  // Grant decode: on a tie the master not granted last wins; held off in reset.
  assign w_gnt0    = !i_reset && (r_state == S_IDLE) && i_m0_req && (!i_m1_req || !r_prio_m1);
  assign w_gnt1    = !i_reset && (r_state == S_IDLE) && i_m1_req && (!i_m0_req ||  r_prio_m1);
  assign w_any_gnt = w_gnt0 || w_gnt1;

  assign w_sel_we    = w_gnt1 ? i_m1_we    : i_m0_we;
  assign w_sel_addr  = w_gnt1 ? i_m1_addr  : i_m0_addr;
  assign w_sel_wdata = w_gnt1 ? i_m1_wdata : i_m0_wdata;
  assign w_region    = w_sel_addr[31:28];
  assign w_timeout   = (r_cnt == CNT_W'(IO_TIMEOUT - 1));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_any_gnt) begin
          case (w_region)
            REG_DMEM: w_next = S_DMEM;
            REG_IO:   w_next = S_IO_WAIT;
            default:  w_next = S_RESP;
          endcase
        end
      end
      S_DMEM:    w_next = S_RESP;
      S_IO_WAIT: if (i_io_ready || w_timeout) w_next = S_RESP;
      S_RESP:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Capture registers, round-robin pointer and IO wait counter.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_prio_m1  <= 1'b0;
      r_mid      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_err      <= 1'b0;
      r_io_rdata <= '0;
      r_cnt      <= '0;
    end else begin
      if (r_state == S_IDLE && w_any_gnt) begin
        r_prio_m1  <= w_gnt0;
        r_mid      <= w_gnt1;
        r_we       <= w_sel_we;
        r_addr     <= w_sel_addr;
        r_wdata    <= w_sel_wdata;
        r_err      <= (w_region != REG_DMEM) && (w_region != REG_IO);
        r_io_rdata <= '0;
        r_cnt      <= '0;
      end else if (r_state == S_IO_WAIT) begin
        // A ready in the final counted cycle still wins over the timeout.
        if (i_io_ready) begin
          r_io_rdata <= i_io_rdata;
        end else if (w_timeout) begin
          r_err <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign w_rdata = (r_err || r_we)           ? 32'h0 :
                   (r_addr[31:28] == REG_IO) ? r_io_rdata : i_dmem_rdata;

  always_comb begin
    o_m0_gnt     = 1'b0;
    o_m1_gnt     = 1'b0;
    o_m0_rvalid  = 1'b0;
    o_m1_rvalid  = 1'b0;
    o_m0_rdata   = '0;
    o_m1_rdata   = '0;
    o_m0_err     = 1'b0;
    o_m1_err     = 1'b0;
    o_dmem_en    = 1'b0;
    o_dmem_wren  = 1'b0;
    o_dmem_addr  = '0;
    o_dmem_wdata = '0;
    o_io_req     = 1'b0;
    o_io_wren    = 1'b0;
    o_io_addr    = '0;
    o_io_wdata   = '0;
    case (r_state)
      S_IDLE: begin
        o_m0_gnt = w_gnt0;
        o_m1_gnt = w_gnt1;
      end
      S_DMEM: begin
        o_dmem_en    = 1'b1;
        o_dmem_wren  = r_we;
        o_dmem_addr  = r_addr;
        o_dmem_wdata = r_wdata;
      end
      S_IO_WAIT: begin
        o_io_req   = 1'b1;
        o_io_wren  = r_we;
        o_io_addr  = r_addr;
        o_io_wdata = r_wdata;
      end
      S_RESP: begin
        if (r_mid) begin
          o_m1_rvalid = 1'b1;
          o_m1_rdata  = w_rdata;
          o_m1_err    = r_err;
        end else begin
          o_m0_rvalid = 1'b1;
          o_m0_rdata  = w_rdata;
          o_m0_err    = r_err;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter against a transaction-level model of
// grant order, per-region latency and response contents.
module tb_mem_bus_arbiter;

  localparam int unsigned TMO = 16;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_m0_req, i_m0_we, i_m1_req, i_m1_we;
  logic [31:0] i_m0_addr, i_m0_wdata, i_m1_addr, i_m1_wdata;
  logic        o_m0_gnt, o_m0_rvalid, o_m0_err, o_m1_gnt, o_m1_rvalid, o_m1_err;
  logic [31:0] o_m0_rdata, o_m1_rdata;
  logic        o_dmem_en, o_dmem_wren, o_io_req, o_io_wren, i_io_ready;
  logic [31:0] o_dmem_addr, o_dmem_wdata, i_dmem_rdata;
  logic [31:0] o_io_addr, o_io_wdata, i_io_rdata;

  mem_bus_arbiter #(.IO_TIMEOUT(TMO)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_m0_req(i_m0_req), .i_m0_we(i_m0_we), .i_m0_addr(i_m0_addr), .i_m0_wdata(i_m0_wdata),
    .o_m0_gnt(o_m0_gnt), .o_m0_rvalid(o_m0_rvalid), .o_m0_rdata(o_m0_rdata), .o_m0_err(o_m0_err),
    .i_m1_req(i_m1_req), .i_m1_we(i_m1_we), .i_m1_addr(i_m1_addr), .i_m1_wdata(i_m1_wdata),
    .o_m1_gnt(o_m1_gnt), .o_m1_rvalid(o_m1_rvalid), .o_m1_rdata(o_m1_rdata), .o_m1_err(o_m1_err),
    .o_dmem_en(o_dmem_en), .o_dmem_wren(o_dmem_wren), .o_dmem_addr(o_dmem_addr),
    .o_dmem_wdata(o_dmem_wdata), .i_dmem_rdata(i_dmem_rdata),
    .o_io_req(o_io_req), .o_io_wren(o_io_wren), .o_io_addr(o_io_addr), .o_io_wdata(o_io_wdata),
    .i_io_ready(i_io_ready), .i_io_rdata(i_io_rdata)
  );

  always #5 i_clk = ~i_clk;

  int          n_checks = 0;
  int          n_errors = 0;
  bit          exp_prio_m1;
  logic [31:0] dmem_rd, io_rd;
  logic        m_we    [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  int          m_k     [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {22'h0, o_dmem_en, o_dmem_wren, o_io_req, o_io_wren, o_m0_gnt,
                          o_m1_gnt, o_m0_rvalid, o_m1_rvalid, o_m0_err, o_m1_err}, 32'h0);
    check({tag, "_data"}, o_dmem_addr | o_dmem_wdata | o_io_addr | o_io_wdata |
                          o_m0_rdata | o_m1_rdata, 32'h0);
  endtask

  task automatic drive_req(input int m, input bit v);
    if (m == 0) begin
      i_m0_req = v; i_m0_we = m_we[0]; i_m0_addr = m_addr[0]; i_m0_wdata = m_wdata[0];
    end else begin
      i_m1_req = v; i_m1_we = m_we[1]; i_m1_addr = m_addr[1]; i_m1_wdata = m_wdata[1];
    end
  endtask

  task automatic rand_master(input int m);
    int r;
    logic [3:0] rg;
    r = int'($urandom_range(0, 9));
    rg = (r < 4) ? 4'h0 : (r < 8) ? 4'h1 : 4'($urandom_range(2, 15));
    m_we[m]    = 1'($urandom);
    m_addr[m]  = {rg, 28'($urandom)};
    m_wdata[m] = $urandom;
    m_k[m]     = int'($urandom_range(0, TMO + 2));
  endtask

  task automatic set_master(input int m, input logic we, input logic [31:0] a, input int k);
    m_we[m] = we; m_addr[m] = a; m_wdata[m] = $urandom; m_k[m] = k;
  endtask

  // Follow one granted transaction of master g from the cycle after grant to rvalid.
  task automatic serve(input int g, input bit glitch);
    bit          is_dmem, is_io, ok_io, exp_err;
    int          lat;
    logic [31:0] exp_rd;
    is_dmem = (m_addr[g][31:28] == 4'h0);
    is_io   = (m_addr[g][31:28] == 4'h1);
    ok_io   = is_io && (m_k[g] < int'(TMO));
    lat     = is_dmem ? 2 : ok_io ? m_k[g] + 2 : is_io ? int'(TMO) + 1 : 1;
    exp_err = !(is_dmem || ok_io);
    exp_rd  = (exp_err || m_we[g]) ? 32'h0 : is_dmem ? dmem_rd : io_rd;
    i_dmem_rdata = dmem_rd;
    @(posedge i_clk); #1;
    drive_req(g, 1'b0);
    for (int t = 1; t <= lat; t++) begin
      if (t > 1) begin @(posedge i_clk); #1; end
      i_io_ready = ok_io && (t == m_k[g] + 1);
      i_io_rdata = i_io_ready ? io_rd : ~io_rd;
      if (glitch && t == 1) drive_req(1 - g, 1'b1);
      if (glitch && t == lat) drive_req(1 - g, 1'b0);
      @(negedge i_clk);
      check("busy_gnt", {30'h0, o_m1_gnt, o_m0_gnt}, 32'h0);
      check("dmem_en", {31'h0, o_dmem_en}, {31'h0, is_dmem && t == 1});
      if (is_dmem && t == 1) begin
        check("dmem_wren", {31'h0, o_dmem_wren}, {31'h0, m_we[g]});
        check("dmem_addr", o_dmem_addr, m_addr[g]);
        check("dmem_wdata", o_dmem_wdata, m_wdata[g]);
      end
      check("io_req", {31'h0, o_io_req}, {31'h0, is_io && t < lat});
      if (is_io && t < lat) begin
        check("io_wren", {31'h0, o_io_wren}, {31'h0, m_we[g]});
        check("io_addr", o_io_addr, m_addr[g]);
        check("io_wdata", o_io_wdata, m_wdata[g]);
      end
      check("rvalid", {30'h0, o_m1_rvalid, o_m0_rvalid},
            (t == lat) ? ((g == 0) ? 32'h1 : 32'h2) : 32'h0);
      if (t == lat) begin
        check("rdata", (g == 0) ? o_m0_rdata : o_m1_rdata, exp_rd);
        check("err", {31'h0, (g == 0) ? o_m0_err : o_m1_err}, {31'h0, exp_err});
      end
    end
    @(posedge i_clk); #1;
    i_io_ready = 1'b0;
  endtask

  // Raise the chosen requests and serve every requester in model-predicted order.
  task automatic run_round(input bit r0, input bit r1, input bit glitch);
    bit p0, p1;
    int g;
    p0 = r0; p1 = r1;
    if (r0) drive_req(0, 1'b1);
    if (r1) drive_req(1, 1'b1);
    while (p0 || p1) begin
      @(negedge i_clk);
      g = (p0 && p1) ? (exp_prio_m1 ? 1 : 0) : (p0 ? 0 : 1);
      check("gnt", {30'h0, o_m1_gnt, o_m0_gnt}, (g == 0) ? 32'h1 : 32'h2);
      exp_prio_m1 = (g == 0);
      serve(g, glitch && !(p0 && p1));
      if (g == 0) p0 = 1'b0; else p1 = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    i_reset = 1'b1; i_io_ready = 1'b0; i_io_rdata = '0; i_dmem_rdata = '0;
    for (int m = 0; m < 2; m++) set_master(m, 1'b0, 32'h0, 0);
    drive_req(0, 1'b0); drive_req(1, 1'b0);
    exp_prio_m1 = 1'b0;
    repeat (2) @(posedge i_clk);
    i_m0_req = 1'b1;
    @(negedge i_clk);
    check_all_zero("reset");
    i_m0_req = 1'b0;
    i_reset = 1'b0;
    @(posedge i_clk); #1;

    // DMEM load with a known value.
    set_master(0, 1'b0, 32'h0000_0010, 0);
    dmem_rd = 32'hDEAD_BEEF; io_rd = $urandom;
    run_round(1'b1, 1'b0, 1'b0);

    // Tie: M0 DMEM load first, then M1 IO store readied after 3 wait cycles.
    set_master(0, 1'b0, 32'h0000_0100, 0);
    set_master(1, 1'b1, 32'h1000_0000, 3);
    dmem_rd = $urandom; io_rd = $urandom;
    run_round(1'b1, 1'b1, 1'b0);

    // IO load that never sees ready: timeout with error.
    set_master(1, 1'b0, 32'h1001_0000, TMO + 5);
    run_round(1'b0, 1'b1, 1'b0);

    // Unmapped region.
    set_master(0, 1'b0, 32'h2000_0000, 0);
    run_round(1'b1, 1'b0, 1'b0);

    // Ready in the very last wait cycle counts as success.
    set_master(0, 1'b0, 32'h1000_0004, TMO - 1);
    io_rd = $urandom;
    run_round(1'b1, 1'b0, 1'b0);

    // M1 pulses its request while busy and drops it: no grant, pointer unchanged.
    set_master(0, 1'b0, 32'h0000_0020, 0);
    set_master(1, 1'b0, 32'h0000_0030, 0);
    run_round(1'b1, 1'b0, 1'b1);
    rand_master(0); rand_master(1);
    run_round(1'b1, 1'b1, 1'b0);

    // Reset in the middle of an IO wait aborts the transaction.
    set_master(1, 1'b0, 32'h1000_0040, TMO + 5);
    drive_req(1, 1'b1);
    @(negedge i_clk);
    check("rst_gnt", {30'h0, o_m1_gnt, o_m0_gnt}, 32'h2);
    @(posedge i_clk); #1;
    drive_req(1, 1'b0);
    repeat (2) @(posedge i_clk);
    #1;
    check("pre_rst_io_req", {31'h0, o_io_req}, 32'h1);
    #1 i_reset = 1'b1;
    #1;
    check("rst_io_req", {31'h0, o_io_req}, 32'h0);
    check_all_zero("rst_mid");
    @(negedge i_clk);
    i_reset = 1'b0;
    exp_prio_m1 = 1'b0;
    for (int c = 0; c < int'(TMO) + 4; c++) begin
      @(negedge i_clk);
      check("no_rvalid", {30'h0, o_m1_rvalid, o_m0_rvalid}, 32'h0);
    end
    @(posedge i_clk); #1;
    rand_master(0); rand_master(1);
    dmem_rd = $urandom; io_rd = $urandom;
    run_round(1'b1, 1'b1, 1'b0);

    for (int n = 0; n < 60; n++) begin
      int sel;
      bit r0, r1;
      sel = int'($urandom_range(1, 3));
      r0 = sel[0]; r1 = sel[1];
      rand_master(0); rand_master(1);
      dmem_rd = $urandom; io_rd = $urandom;
      run_round(r0, r1, 1'($urandom) && !(r0 && r1));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter IO_TIMEOUT, default 16, max cycles to wait for i_io_ready before erroring.
REQ-002 SHALL have port i_clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port i_reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have, for X in {0,1}, port i_mX_req  in  1  master X request, held until granted.
REQ-005 SHALL have port i_mX_we  in  1  master X store (1) / load (0).
REQ-006 SHALL have port i_mX_addr  in  32  master X byte address.
REQ-007 SHALL have port i_mX_wdata  in  32  master X store data.
REQ-008 SHALL have port o_mX_gnt  out  1  one-cycle grant pulse; request captured this cycle.
REQ-009 SHALL have port o_mX_rvalid  out  1  one-cycle response pulse.
REQ-010 SHALL have port o_mX_rdata  out  32  load data, valid with rvalid.
REQ-011 SHALL have port o_mX_err  out  1  access error flag, valid with rvalid.
REQ-012 SHALL have port o_dmem_en, o_dmem_wren  out  1 each  DMEM access strobe / write enable.
REQ-013 SHALL have port o_dmem_addr, o_dmem_wdata  out  32 each  DMEM address / store data.
REQ-014 SHALL have port i_dmem_rdata  in  32  DMEM load data, valid cycle after o_dmem_en.
REQ-015 SHALL have port o_io_req, o_io_wren  out  1 each  IO request (level) / write enable.
REQ-016 SHALL have port o_io_addr, o_io_wdata  out  32 each  IO address / store data.
REQ-017 SHALL have ports i_io_ready  in  1  and  i_io_rdata  in  32  IO completion strobe and load data.

Function
REQ-018 SHALL implement FSM states IDLE, DMEM, IO_WAIT, RESP.
REQ-019 IDLE: if any i_mX_req, o_mX_gnt SHALL assert combinationally for exactly one master; addr/we/wdata/master-id registered; next state chosen by region.
REQ-020 Both requesting: SHALL grant the master not granted most recently; after reset, M0 wins first tie.
REQ-021 Region decode on captured addr[31:28]: 0x0 -> DMEM, 0x1 -> IO, any other -> error (straight to RESP).
REQ-022 DMEM state (one cycle): o_dmem_en=1, o_dmem_wren=we, addr/wdata from capture registers; then RESP.
REQ-023 IO_WAIT: o_io_req=1, o_io_wren=we, addr/wdata stable until i_io_ready; i_io_rdata captured on ready; then RESP.
REQ-024 IO_WAIT counter: 0 on entry, increments per cycle without ready; reaching IO_TIMEOUT-1 without ready -> RESP with error, o_io_req drops.
REQ-025 i_io_ready in the same cycle as timeout SHALL count as success, not error.
REQ-026 RESP (one cycle): o_mX_rvalid=1 for captured master only; rdata = DMEM/IO load data for loads, 0 for stores and errors; err=1 only for bad region or timeout; then IDLE.
REQ-027 Latency from grant: DMEM 2 cycles to rvalid; IO (ready after k cycles in IO_WAIT) k+2; bad region 1.
REQ-028 No grant outside IDLE; requests during busy states SHALL wait; back-to-back transactions spaced by 3 cycles minimum (IDLE, DMEM, RESP).
REQ-029 Request deasserted before grant SHALL cause no transaction and no pointer update.
REQ-030 All outputs not specified active in a state SHALL be 0 in that state.

Reset
REQ-031 i_reset high SHALL immediately force IDLE, round-robin pointer to favour M0, counter 0, all outputs 0, capture registers 0.
REQ-032 Reset during DMEM/IO_WAIT/RESP SHALL abort the transaction with no rvalid after release; o_io_req drops asynchronously.

Verification
REQ-033 M0 load 0x0000_0010, i_dmem_rdata=0xDEAD_BEEF -> gnt0 cycle 0, o_dmem_en cycle 1, o_m0_rvalid cycle 2 with rdata 0xDEAD_BEEF, err 0.
REQ-034 M0 and M1 request together twice -> first grant M0, second M1; M1 store to 0x1000_0000 drives o_io_req until i_io_ready 3 cycles later, rvalid rdata 0.
REQ-035 M1 load 0x1001_0000, i_io_ready never asserted -> o_io_req high 16 cycles, then o_m1_rvalid with err=1, rdata 0.
REQ-036 M0 load 0x2000_0000 -> no DMEM/IO strobe, o_m0_rvalid next cycle with err=1.
REQ-037 Assert i_reset mid IO_WAIT -> o_io_req low same cycle, no rvalid, next tie grants M0.
